// File: rtl/spio_spl_pkg.sv
// Shared SpiNNaker link definitions: packet field bounds, flit counts,
// 2-of-7 NRZ code table and the transmitter state encoding.
package spio_spl_pkg;

  localparam int PKT_W        = 72;
  localparam int HDR_MSB      = 7;
  localparam int KEY_MSB      = 39;
  localparam int PLD_MSB      = 71;
  localparam int HDR_LONG_BIT = 1;

  localparam logic [4:0] FLITS_SHORT = 5'd10;
  localparam logic [4:0] FLITS_LONG  = 5'd18;
  localparam logic [4:0] SYM_EOP     = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } spl_tx_state_e;

  // Symbols 0..15 are data nibbles, 16 is end-of-packet.
  function automatic logic [6:0] code_2of7(input logic [4:0] sym);
    logic [6:0] c;
    case (sym)
      5'd0:    c = 7'b0010001;
      5'd1:    c = 7'b0010010;
      5'd2:    c = 7'b0010100;
      5'd3:    c = 7'b0011000;
      5'd4:    c = 7'b0100001;
      5'd5:    c = 7'b0100010;
      5'd6:    c = 7'b0100100;
      5'd7:    c = 7'b0101000;
      5'd8:    c = 7'b1000001;
      5'd9:    c = 7'b1000010;
      5'd10:   c = 7'b1000100;
      5'd11:   c = 7'b1001000;
      5'd12:   c = 7'b0000011;
      5'd13:   c = 7'b0000110;
      5'd14:   c = 7'b0001100;
      5'd15:   c = 7'b0001001;
      5'd16:   c = 7'b1100000;
      default: c = 7'b0000000;
    endcase
    return c;
  endfunction

  // Rewrite hdr[0] so the XOR over every transmitted bit is 1.
  function automatic logic [PKT_W-1:0] parity_fix(input logic [PKT_W-1:0] pkt);
    logic [PKT_W-1:0] p;
    p = pkt;
    if (pkt[HDR_LONG_BIT]) p[0] = ~(^pkt[PLD_MSB:1]);
    else                   p[0] = ~(^pkt[KEY_MSB:1]);
    return p;
  endfunction

endpackage

// File: rtl/spio_spinnaker_link_transmitter_nrz_if.sv
// Packet input handshake and off-chip NRZ link signals of the transmitter.
interface spio_spinnaker_link_transmitter_nrz_if;
  logic [71:0] pkt_data;
  logic        pkt_vld;
  logic        pkt_rdy;
  logic [6:0]  sl_data_2of7;
  logic        sl_ack;

  modport master (output pkt_data, pkt_vld, sl_ack,
                  input  pkt_rdy, sl_data_2of7);
  modport slave  (input  pkt_data, pkt_vld, sl_ack,
                  output pkt_rdy, sl_data_2of7);
endinterface

// File: rtl/spio_spinnaker_link_sync.sv
// One resettable register stage of a synchroniser; chain instances for depth.
module spio_spinnaker_link_sync #(
  parameter int SIZE = 1
) (
  input  logic            CLK_IN,
  input  logic            RESET_IN,
  input  logic [SIZE-1:0] IN,
  output logic [SIZE-1:0] OUT
);
  always_ff @(posedge CLK_IN or negedge RESET_IN)
    if (!RESET_IN) OUT <= '0;
    else           OUT <= IN;
endmodule

// File: rtl/spio_spinnaker_link_transmitter_nrz.sv
// SpiNNaker link transmitter: 72-bit packets out as NRZ 2-of-7 flits + EOP.
// Define SPIO_SPL_TX_PARITY_FIX_EN to force odd parity via hdr[0] on accept.
module spio_spinnaker_link_transmitter_nrz
  import spio_spl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                                   CLK_IN,
  input  logic                                   RESET_IN,
  spio_spinnaker_link_transmitter_nrz_if.slave   ifc
);

  spl_tx_state_e    state_q, state_d;
  logic [PKT_W-1:0] pkt_q, pkt_d, pkt_in;
  logic [4:0]       cnt_q, cnt_d, last_cnt, sym;
  logic [3:0]       nib;
  logic [6:0]       data_q, data_d;
  logic             ack_ref_q, ack_ref_d, rdy_q, rdy_d, ack_s;
  logic [SYNC_STAGES:0] ack_pipe;

  // Ack crosses in asynchronously; one sync stage per pipe slot.
  assign ack_pipe[0] = ifc.sl_ack;
  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    spio_spinnaker_link_sync #(.SIZE(1)) u_sync (
      .CLK_IN   (CLK_IN),
      .RESET_IN (RESET_IN),
      .IN       (ack_pipe[g]),
      .OUT      (ack_pipe[g+1])
    );
  end
  assign ack_s = ack_pipe[SYNC_STAGES];

`ifdef SPIO_SPL_TX_PARITY_FIX_EN
  assign pkt_in = parity_fix(ifc.pkt_data);
`else
  assign pkt_in = ifc.pkt_data;
`endif

  assign last_cnt = pkt_q[HDR_LONG_BIT] ? FLITS_LONG : FLITS_SHORT;
  assign nib      = pkt_q[{cnt_q, 2'b00} +: 4];
  assign sym      = (cnt_q == last_cnt) ? SYM_EOP : {1'b0, nib};

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q   <= ST_IDLE;
      pkt_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      ack_ref_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      ack_ref_q <= ack_ref_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ack_ref_d = ack_ref_q;
    rdy_d     = rdy_q;
    case (state_q)
      ST_IDLE: begin
        rdy_d     = 1'b1;
        ack_ref_d = ack_s;
        if (ifc.pkt_vld && rdy_q) begin
          pkt_d   = pkt_in;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        data_d    = data_q ^ code_2of7(sym);
        // Sampling here lets WAIT catch an ack edge that lands during SEND.
        ack_ref_d = ack_s;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_s != ack_ref_q) begin
          if (cnt_q == last_cnt) begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ifc.pkt_rdy      = rdy_q;
  assign ifc.sl_data_2of7 = data_q;

endmodule

// File: tb/tb_spio_spinnaker_link_transmitter_nrz.sv
// Randomised bench for the NRZ link transmitter with an ack-responding partner.
module tb_spio_spinnaker_link_transmitter_nrz;
  localparam int SYNC_STAGES = 2;

  logic tb_clk = 1'b0;
  logic tb_rst;
  always #5 tb_clk = ~tb_clk;

  spio_spinnaker_link_transmitter_nrz_if ifc ();

  spio_spinnaker_link_transmitter_nrz #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK_IN   (tb_clk),
    .RESET_IN (tb_rst),
    .ifc      (ifc)
  );

  logic [6:0] code_tbl [0:15] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                                  7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09};
  localparam logic [6:0] EOP_CODE = 7'h60;

  int checks = 0, failures = 0;
  logic [6:0] obs_q[$];
  logic [6:0] exp_q[$];
  logic [6:0] exp_run = '0;
  int  sent_cnt = 0, ack_cnt = 0, spur_req = 0, spur_done = 0;
  bit  ack_en = 1'b1, mon_en = 1'b0;
  int  cyc = 0, acc_cyc = 0, tog_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge tb_clk) begin
    cyc <= cyc + 1;
    if (ifc.pkt_vld && ifc.pkt_rdy) acc_cyc <= cyc + 1;
  end

  // Link partner: every new symbol is recorded and acked 23ns later.
  always @(ifc.sl_data_2of7) begin
    if (mon_en) begin
      obs_q.push_back(ifc.sl_data_2of7);
      sent_cnt++;
    end
  end

  initial begin
    ifc.sl_ack = 1'b0;
    forever begin
      wait (sent_cnt != ack_cnt || spur_req != spur_done);
      if (spur_req != spur_done) begin
        spur_done++;
        ifc.sl_ack = ~ifc.sl_ack;
      end else begin
        #23;
        wait (ack_en);
        ack_cnt++;
        tog_cyc = cyc;
        ifc.sl_ack = ~ifc.sl_ack;
      end
    end
  end

  function automatic logic [71:0] eff_pkt(input logic [71:0] p);
    logic [71:0] q;
    bit par;
    q = p;
`ifdef SPIO_SPL_TX_PARITY_FIX_EN
    par = 1'b0;
    for (int i = 1; i < (p[1] ? 72 : 40); i++) par ^= p[i];
    q[0] = ~par;
`else
    par = 1'b0;
`endif
    return q;
  endfunction

  // Reference: each nibble (LSB first) toggles its code onto the wires, then EOP.
  task automatic push_expected(input logic [71:0] p);
    logic [71:0] e;
    int n;
    e = eff_pkt(p);
    n = e[1] ? 18 : 10;
    for (int i = 0; i < n; i++) begin
      exp_run ^= code_tbl[(e >> (4 * i)) & 72'hF];
      exp_q.push_back(exp_run);
    end
    exp_run ^= EOP_CODE;
    exp_q.push_back(exp_run);
  endtask

  task automatic send_pkt(input logic [71:0] p, input bit keep_vld, input string tag);
    bit ok = 1'b0;
    @(negedge tb_clk);
    ifc.pkt_data = p;
    ifc.pkt_vld  = 1'b1;
    for (int i = 0; i < 20000 && !ok; i++) begin
      if (ifc.pkt_rdy) begin
        @(posedge tb_clk);
        ok = 1'b1;
      end else @(negedge tb_clk);
    end
    check({tag, "_accept"}, ok, 1);
    if (ok) push_expected(p);
    @(negedge tb_clk);
    if (!keep_vld) ifc.pkt_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge tb_clk);
      if (obs_q.size() >= exp_q.size() && ifc.pkt_rdy && sent_cnt == ack_cnt) done = 1'b1;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic compare_streams(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_sym"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_syms(input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge tb_clk);
      if (obs_q.size() >= n) ok = 1'b1;
    end
    check({tag, "_progress"}, ok, 1);
  endtask

  function automatic logic [71:0] rnd_pkt(input bit force_len, input bit long_pkt);
    logic [71:0] p;
    p = {$urandom, $urandom, 8'($urandom)};
    if (force_len) p[1] = long_pkt;
    return p;
  endfunction

  initial begin
    logic [71:0] p;
    logic [6:0]  snap, prev;
    int          n, dec;
    bit          par;

    tb_rst = 1'b0;
    ifc.pkt_vld  = 1'b0;
    ifc.pkt_data = '0;
    repeat (3) @(negedge tb_clk);
    check("rst_rdy", ifc.pkt_rdy, 0);
    check("rst_data", ifc.sl_data_2of7, 0);
    tb_rst = 1'b1;
    mon_en = 1'b1;
    @(negedge tb_clk);
    check("rdy_first_edge", ifc.pkt_rdy, 1);
    repeat (20) @(negedge tb_clk);
    check("idle_rdy", ifc.pkt_rdy, 1);
    check("idle_data", ifc.sl_data_2of7, 0);
    check("idle_nosym", obs_q.size(), 0);

    // Ack toggle while idle must be absorbed.
    spur_req++;
    repeat (20) @(negedge tb_clk);
    check("spur_nosym", obs_q.size(), 0);
    check("spur_rdy", ifc.pkt_rdy, 1);

    // Directed short packet, with first-symbol latency.
    p = {32'h0, 32'h1, 8'h00};
    @(negedge tb_clk);
    ifc.pkt_data = p;
    ifc.pkt_vld  = 1'b1;
    check("dir_rdy_pre", ifc.pkt_rdy, 1);
    @(posedge tb_clk);
    push_expected(p);
    @(negedge tb_clk);
    ifc.pkt_vld = 1'b0;
    check("lat_edge_k", ifc.sl_data_2of7, 7'h00);
    check("lat_rdy_low", ifc.pkt_rdy, 0);
    @(negedge tb_clk);
    check("lat_edge_k1", ifc.sl_data_2of7, 7'h11);
    wait_done("dir");
    if (obs_q.size() == 11) begin
      check("dir_s0", obs_q[0], 7'h11);
      check("dir_s1", obs_q[1], 7'h00);
      check("dir_s2", obs_q[2], 7'h12);
      check("dir_s3", obs_q[3], 7'h03);
      check("dir_eop", obs_q[10], obs_q[9] ^ 7'h60);
    end
    compare_streams("dir");
    check("dir_rdy_post", ifc.pkt_rdy, 1);

    // Long packet: 18 data flits + EOP.
    p = {32'hA5A5A5A5, $urandom, 8'h02};
    send_pkt(p, 1'b0, "long");
    wait_done("long");
    check("long_count", obs_q.size(), 19);
    compare_streams("long");

    // Parity: hdr[0] deliberately wrong (even overall parity).
    p = rnd_pkt(1'b1, 1'b0);
    par = 1'b0;
    for (int i = 1; i < 40; i++) par ^= p[i];
    p[0] = par;
    prev = ifc.sl_data_2of7;
    send_pkt(p, 1'b0, "par");
    wait_done("par");
    dec = -1;
    if (obs_q.size() > 0)
      for (int j = 0; j < 16; j++) if (code_tbl[j] == (obs_q[0] ^ prev)) dec = j;
`ifdef SPIO_SPL_TX_PARITY_FIX_EN
    check("par_hdr0", dec & 1, {31'b0, ~par});
`else
    check("par_hdr0", dec & 1, {31'b0, par});
`endif
    compare_streams("par");

    // Ack withheld mid-packet.
    p = rnd_pkt(1'b1, 1'b1);
    send_pkt(p, 1'b0, "hold");
    wait_syms(5, "hold");
    ack_en = 1'b0;
    repeat (10) @(negedge tb_clk);
    snap = ifc.sl_data_2of7;
    n = obs_q.size();
    repeat (500) @(negedge tb_clk);
    check("hold_data", ifc.sl_data_2of7, snap);
    check("hold_nsym", obs_q.size(), n);
    check("hold_rdy", ifc.pkt_rdy, 0);
    ack_en = 1'b1;
    wait_done("hold");
    compare_streams("hold");

    // Back-to-back packets with VLD held high.
    for (int k = 0; k < 50; k++) begin
      send_pkt(rnd_pkt(1'b0, 1'b0), 1'b1, "b2b");
      if (k > 0) check("b2b_gap", acc_cyc - tog_cyc, SYNC_STAGES + 2);
    end
    ifc.pkt_vld = 1'b0;
    wait_done("b2b");
    compare_streams("b2b");

    // Reset mid-packet forces outputs asynchronously.
    send_pkt(rnd_pkt(1'b0, 1'b0), 1'b0, "mrst");
    wait_syms(3, "mrst");
    mon_en = 1'b0;
    @(negedge tb_clk);
    #2 tb_rst = 1'b0;
    #1;
    check("mrst_data", ifc.sl_data_2of7, 0);
    check("mrst_rdy", ifc.pkt_rdy, 0);
    repeat (2) @(negedge tb_clk);
    tb_rst = 1'b1;
    obs_q.delete();
    exp_q.delete();
    exp_run = '0;
    repeat (10) @(negedge tb_clk);
    mon_en = 1'b1;
    check("post_rst_rdy", ifc.pkt_rdy, 1);
    check("post_rst_data", ifc.sl_data_2of7, 0);
    send_pkt(rnd_pkt(1'b0, 1'b0), 1'b0, "post");
    wait_done("post");
    compare_streams("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
